// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse controller slice.
// Build option EFUSE_PGM_VERIFY_EN (see efuse_ctrl) does not affect this package.
package efuse_pkg;

  localparam int EFUSE_BITS        = 128;
  localparam int EFUSE_AW          = $clog2(EFUSE_BITS);
  localparam int SETUP_CYC_DEF     = 2;
  localparam int RD_STROBE_CYC_DEF = 4;
  localparam int PGM_PULSE_CYC_DEF = 200;

  typedef enum logic [2:0] {
    IDLE,
    LD_SETUP,
    LD_STROBE,
    PG_SETUP,
    PG_PULSE,
    PG_HOLD
  } efuse_state_e;

  typedef struct packed {
    logic                efuse_mode;
    logic [EFUSE_AW-1:0] efuse_bit_addr;
  } str_reg_efuse_config;

  typedef struct packed {
    logic efuse_wr;
    logic efuse_rd;
    logic efuse_op_done;
  } str_reg_efuse_status;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/efuse_if.sv
// Pin bundle between the controller (master) and the analog eFuse macro (slave).
interface efuse_if;
  import efuse_pkg::*;

  logic [EFUSE_AW-1:0] efuse_addr;
  logic                efuse_rden;
  logic                efuse_pgm;
  logic                efuse_vddq_en;
  logic                efuse_dout;

  modport master (
    output efuse_addr, efuse_rden, efuse_pgm, efuse_vddq_en,
    input  efuse_dout
  );

  modport slave (
    input  efuse_addr, efuse_rden, efuse_pgm, efuse_vddq_en,
    output efuse_dout
  );

endinterface

// File: rtl/efuse_phase_tmr.sv
// Loadable down-counter timing each FSM phase; last_cyc flags the final cycle.
module efuse_phase_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last_cyc
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last_cyc = (cnt == '0);

endmodule

// File: rtl/efuse_ctrl.sv
// eFuse controller: auto-load after reset, SPI program-bit / reload-all, 128-bit shadow.
// Define EFUSE_PGM_VERIFY_EN to add a read-back verify after each program pulse.
module efuse_ctrl
  import efuse_pkg::*;
#(
  parameter int SETUP_CYC     = SETUP_CYC_DEF,
  parameter int RD_STROBE_CYC = RD_STROBE_CYC_DEF,
  parameter int PGM_PULSE_CYC = PGM_PULSE_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_req,
  input  logic                  efuse_mode,
  input  logic [EFUSE_AW-1:0]   efuse_bit_addr,
  input  logic                  op_done_clr,
  efuse_if.master               macro,
  output logic [EFUSE_BITS-1:0] efuse_data,
  output logic                  efuse_done,
  output logic                  efuse_rd,
  output logic                  efuse_wr,
  output logic                  efuse_op_done,
  output logic                  efuse_pgm_fail
);

  localparam int TW = $clog2(max3(SETUP_CYC, RD_STROBE_CYC, PGM_PULSE_CYC) + 1);

  efuse_state_e        state, state_nxt;
  str_reg_efuse_config cfg;
  str_reg_efuse_status status;
  logic [EFUSE_AW-1:0] addr_q;
  logic                done_q, req_q, op_done_q, verify_q;
  logic                tmr_load, last_cyc;
  logic [TW-1:0]       tmr_val;
  logic                accept, capture, finish, pg_commit, verify_start;

  assign cfg = '{efuse_mode: efuse_mode, efuse_bit_addr: efuse_bit_addr};

  efuse_phase_tmr #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last_cyc (last_cyc)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    capture      = 1'b0;
    finish       = 1'b0;
    pg_commit    = 1'b0;
    verify_start = 1'b0;
    case (state)
      IDLE: begin
        if (!done_q) begin
          state_nxt = LD_SETUP;
        end else if (op_req) begin
          accept    = 1'b1;
          state_nxt = cfg.efuse_mode ? PG_SETUP : LD_SETUP;
        end
      end
      LD_SETUP:  if (last_cyc) state_nxt = LD_STROBE;
      LD_STROBE: begin
        if (last_cyc) begin
          capture = 1'b1;
          if (verify_q || addr_q == EFUSE_AW'(EFUSE_BITS - 1)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = LD_SETUP;
          end
        end
      end
      PG_SETUP: if (last_cyc) state_nxt = PG_PULSE;
      PG_PULSE: if (last_cyc) state_nxt = PG_HOLD;
      PG_HOLD: begin
        if (last_cyc) begin
`ifdef EFUSE_PGM_VERIFY_EN
          verify_start = 1'b1;
          state_nxt    = LD_SETUP;
`else
          pg_commit = 1'b1;
          finish    = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    tmr_load = (state_nxt != state);
    case (state_nxt)
      LD_SETUP, PG_SETUP, PG_HOLD: tmr_val = TW'(SETUP_CYC - 1);
      LD_STROBE:                   tmr_val = TW'(RD_STROBE_CYC - 1);
      PG_PULSE:                    tmr_val = TW'(PGM_PULSE_CYC - 1);
      default:                     tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      op_done_q <= 1'b0;
      // NOTE: the shadow is a flop array, not a RAM, so resetting it is legal and required.
      efuse_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        addr_q <= cfg.efuse_mode ? cfg.efuse_bit_addr : '0;
      else if (capture && state_nxt == LD_SETUP)
        addr_q <= addr_q + 1'b1;
      if (capture)   efuse_data[addr_q] <= macro.efuse_dout;
      if (pg_commit) efuse_data[addr_q] <= 1'b1;
      if (finish)    done_q <= 1'b1;
      if (accept)      req_q <= 1'b1;
      else if (finish) req_q <= 1'b0;
      // Completion beats a same-cycle clear.
      if (finish && req_q)              op_done_q <= 1'b1;
      else if (op_done_clr || accept)   op_done_q <= 1'b0;
    end
  end

`ifdef EFUSE_PGM_VERIFY_EN
  logic fail_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      verify_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      if (verify_start) verify_q <= 1'b1;
      else if (finish)  verify_q <= 1'b0;
      if (capture && verify_q && !macro.efuse_dout) fail_q <= 1'b1;
      else if (op_done_clr)                         fail_q <= 1'b0;
    end
  end
  assign efuse_pgm_fail = fail_q;
`else
  assign verify_q       = 1'b0;
  assign efuse_pgm_fail = 1'b0;
`endif

  assign status = '{efuse_wr:      (state inside {PG_SETUP, PG_PULSE, PG_HOLD}),
                    efuse_rd:      (state inside {LD_SETUP, LD_STROBE}),
                    efuse_op_done: op_done_q};

  assign efuse_wr            = status.efuse_wr;
  assign efuse_rd            = status.efuse_rd;
  assign efuse_op_done       = status.efuse_op_done;
  assign efuse_done          = done_q;
  assign macro.efuse_addr    = addr_q;
  assign macro.efuse_rden    = (state == LD_STROBE);
  assign macro.efuse_pgm     = (state == PG_PULSE);
  assign macro.efuse_vddq_en = status.efuse_wr;

endmodule

// File: tb/tb_efuse_ctrl.sv
// Directed self-checking bench for efuse_ctrl with a behavioural eFuse macro model.
module tb_efuse_ctrl;

  localparam logic [127:0] PAT = {16{8'hA5}};
`ifdef EFUSE_PGM_VERIFY_EN
  localparam int TOTAL = 210;
  localparam bit IGN3  = 1'b1;
`else
  localparam int TOTAL = 204;
  localparam bit IGN3  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, op_req, efuse_mode, op_done_clr;
  logic [6:0]   efuse_bit_addr;
  logic [127:0] efuse_data;
  logic         efuse_done, efuse_rd, efuse_wr, efuse_op_done, efuse_pgm_fail;

  logic [127:0] fuse = PAT;
  logic         poke;
  logic [6:0]   poke_a;

  int n_cmp = 0;
  int n_bad = 0;

  efuse_if bus ();

  efuse_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .op_req         (op_req),
    .efuse_mode     (efuse_mode),
    .efuse_bit_addr (efuse_bit_addr),
    .op_done_clr    (op_done_clr),
    .macro          (bus),
    .efuse_data     (efuse_data),
    .efuse_done     (efuse_done),
    .efuse_rd       (efuse_rd),
    .efuse_wr       (efuse_wr),
    .efuse_op_done  (efuse_op_done),
    .efuse_pgm_fail (efuse_pgm_fail)
  );

  always #5 clk = ~clk;

  // Macro model: pgm blows the addressed fuse (bit 3 stuck in verify builds).
  always @(posedge clk) begin
    if (poke)
      fuse[poke_a] <= 1'b1;
    else if (bus.efuse_pgm && bus.efuse_vddq_en && !(IGN3 && bus.efuse_addr == 7'd3))
      fuse[bus.efuse_addr] <= 1'b1;
  end
  assign bus.efuse_dout = bus.efuse_rden ? fuse[bus.efuse_addr] : 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic boot(input bit drop, output int k, output logic rd_mid);
    k = 0;
    rd_mid = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      k = i;
      if (i == 10) rd_mid = efuse_rd;
      op_req = drop && (i == 100);
      efuse_mode = 1'b1;
      efuse_bit_addr = 7'd5;
      if (efuse_done) break;
    end
    op_req = 1'b0;
  endtask

  task automatic run_pgm(input logic [6:0] a, input bit collide, input bit drop,
                         output int vcnt, output int pcnt, output int pfirst,
                         output int wr_bad, output int both, output int tcnt);
    vcnt = 0; pcnt = 0; pfirst = -1; wr_bad = 0; both = 0; tcnt = 0;
    op_req = 1'b1; efuse_mode = 1'b1; efuse_bit_addr = a;
    @(negedge clk);
    op_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (efuse_op_done) break;
      tcnt++;
      if (bus.efuse_vddq_en) vcnt++;
      if (bus.efuse_pgm) begin
        pcnt++;
        if (pfirst < 0) pfirst = vcnt;
      end
      if (efuse_wr !== bus.efuse_vddq_en) wr_bad++;
      if (bus.efuse_pgm && bus.efuse_rden) both++;
      op_req = drop && bus.efuse_pgm && (pcnt == 50);
      efuse_mode = !op_req;
      op_done_clr = collide && (tcnt == TOTAL);
      @(negedge clk);
    end
    op_req = 1'b0; op_done_clr = 1'b0; efuse_mode = 1'b1;
  endtask

  initial begin
    int k, vc, pc, pf, wb, bo, tc;
    logic rd_mid, done_low;
    logic [127:0] exp_data;

    rst = 1'b1; op_req = 1'b0; efuse_mode = 1'b0; efuse_bit_addr = '0;
    op_done_clr = 1'b0; poke = 1'b0; poke_a = '0;
    repeat (3) @(negedge clk);
    check("rst_data", efuse_data, '0);
    check("rst_outs", {bus.efuse_addr, bus.efuse_rden, bus.efuse_pgm, bus.efuse_vddq_en,
                       efuse_done, efuse_rd, efuse_wr, efuse_op_done, efuse_pgm_fail}, '0);

    // Auto-load with a dropped request in the middle.
    rst = 1'b0;
    boot(1'b1, k, rd_mid);
    check("boot_cycles", k, 769);
    check("boot_rd_busy", rd_mid, 1'b1);
    check("boot_data", efuse_data, PAT);
    check("boot_op_done", efuse_op_done, 1'b0);
    check("boot_idle_rd", efuse_rd, 1'b0);
    exp_data = PAT;

    // Program 0x55, op_done_clr colliding with completion, request dropped mid-pulse.
    run_pgm(7'h55, 1'b1, 1'b1, vc, pc, pf, wb, bo, tc);
    check("p85_vddq_cycles", vc, 204);
    check("p85_pgm_cycles", pc, 200);
    check("p85_pgm_start", pf, 3);
    check("p85_wr_track", wb, 0);
    check("p85_pgm_rden_excl", bo, 0);
    check("p85_total_cycles", tc, TOTAL);
    check("p85_data", efuse_data, exp_data);
    check("collide_op_done", efuse_op_done, 1'b1);
    op_done_clr = 1'b1;
    @(negedge clk);
    op_done_clr = 1'b0;
    check("clr_op_done", efuse_op_done, 1'b0);

    // Program bit 1 (currently 0).
    run_pgm(7'd1, 1'b0, 1'b0, vc, pc, pf, wb, bo, tc);
    exp_data = exp_data | (128'd1 << 1);
    check("p1_pgm_cycles", pc, 200);
    check("p1_data", efuse_data, exp_data);
    check("p1_op_done", efuse_op_done, 1'b1);
    check("p1_pgm_fail", efuse_pgm_fail, 1'b0);

`ifdef EFUSE_PGM_VERIFY_EN
    // Macro refuses bit 3: verify read must flag it.
    run_pgm(7'd3, 1'b0, 1'b0, vc, pc, pf, wb, bo, tc);
    check("v3_total_cycles", tc, TOTAL);
    check("v3_pgm_fail", efuse_pgm_fail, 1'b1);
    check("v3_data_bit", efuse_data[3], 1'b0);
    check("v3_op_done", efuse_op_done, 1'b1);
    op_done_clr = 1'b1;
    @(negedge clk);
    op_done_clr = 1'b0;
    check("v3_fail_clr", efuse_pgm_fail, 1'b0);
`endif

    // Change the array behind the shadow, then reload all.
    poke = 1'b1; poke_a = 7'd126;
    @(negedge clk);
    poke = 1'b0;
    exp_data = exp_data | (128'd1 << 126);
    op_req = 1'b1; efuse_mode = 1'b0;
    done_low = 1'b0;
    k = 2000;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      op_req = 1'b0;
      if (!efuse_done) done_low = 1'b1;
      if (efuse_op_done) begin
        k = i;
        break;
      end
    end
    check("reload_cycles", k, 769);
    check("reload_data", efuse_data, exp_data);
    check("reload_done_held", done_low, 1'b0);

    // Reset in PG_PULSE cycle 50.
    op_req = 1'b1; efuse_mode = 1'b1; efuse_bit_addr = 7'd0;
    @(negedge clk);
    op_req = 1'b0;
    pc = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.efuse_pgm) pc++;
      if (pc == 50) break;
      @(negedge clk);
    end
    check("abort_reach_pulse", pc, 50);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pgm_vddq", {bus.efuse_pgm, bus.efuse_vddq_en}, 2'b00);
    check("abort_outs", {efuse_data, bus.efuse_addr, bus.efuse_rden, efuse_done,
                         efuse_rd, efuse_wr, efuse_op_done, efuse_pgm_fail}, '0);
    @(negedge clk);
    rst = 1'b0;
    boot(1'b0, k, rd_mid);
    check("reboot_cycles", k, 769);
    check("reboot_data", efuse_data, exp_data);
    check("reboot_op_done", efuse_op_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
